vit_acs_sched: RTL
==================

Name: vit_acs_sched

Overview:
- Time-multiplexed add-compare-select scheduler for an 8-state (K=4, rate 1/2) Viterbi decoder.
- Owns the path-metric register bank and the per-state valid bits, and computes branch metrics from each received symbol.
- Drives one shared combinational ACS unit once per trellis state and collects its results.
- Emits one survivor byte per symbol, plus the current best state, to the downstream traceback/survivor memory.

Parameters:
- G0, 4'b1101, generator polynomial for code bit 1, applied to vector {u, p[2:0]}.
- G1, 4'b1111, generator polynomial for code bit 0, applied to the same vector.
- PM_SAT, 8'd253, clamp on any path metric driven to the ACS, so pmc+bmc never wraps 8 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- init  in  1  one-cycle pulse; re-initialises metrics, aborts any symbol in progress
- sym_valid  in  1  received symbol valid
- sym_ready  out  1  block can accept a symbol
- sym_data  in  2  received hard-decision code pair {c1,c0}
- acs_path_0_valid  out  1  to ACS path_0_valid
- acs_path_1_valid  out  1  to ACS path_1_valid
- acs_path_0_bmc  out  2  to ACS path_0_bmc
- acs_path_1_bmc  out  2  to ACS path_1_bmc
- acs_path_0_pmc  out  8  to ACS path_0_pmc
- acs_path_1_pmc  out  8  to ACS path_1_pmc
- acs_selection  in  1  from ACS selection
- acs_valid  in  1  from ACS valid_o
- acs_path_cost  in  8  from ACS path_cost
- surv_valid  out  1  survivor byte valid
- surv_ready  in  1  downstream accepts survivor byte
- surv_data  out  8  bit s = ACS selection for state s (0 = lower predecessor)
- best_state  out  3  lowest-index valid state with minimum new metric
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a clk edge):
  - pm[0..7] = 0; pv = 8'b0000_0001; state = IDLE; idx = 0.
  - sym_ready = 1; surv_valid = 0; surv_data = 0; best_state = 0; busy = 0.
  - ACS drive outputs = 0.
- Trellis:
  - Next state = {s[1:0], u}.
  - Predecessors of s: p0 = {0, s[2:1]} and p1 = {1, s[2:1]}; input bit u = s[0].
  - Expected code for predecessor p: {^(G0 & {u,p}), ^(G1 & {u,p})}.
  - bmc = Hamming distance between the expected code and the latched symbol (0..2).
- FSM, IDLE -> ACS -> NORM -> EMIT -> IDLE:
  - IDLE:
    - sym_ready = !init.
    - On sym_valid && sym_ready: latch sym_data, set idx = 0, go to ACS.
  - ACS (exactly 8 cycles, idx = 0..7):
    - Drive acs_path_k_valid = pv[pk] and acs_path_k_pmc = min(pm[pk], PM_SAT) for k = 0, 1.
    - Drive acs_path_k_bmc for each predecessor as above.
    - At each clk edge: npm[idx] = acs_valid ? acs_path_cost : 0; npv[idx] = acs_valid; surv_data[idx] = acs_selection.
    - idx increments each cycle; after idx = 7, go to NORM.
    - The ACS drive outputs are 0 outside the ACS state.
  - NORM (1 cycle):
    - m = minimum of npm over states with npv = 1.
    - pm[s] = npv[s] ? npm[s] - m : 0; pv = npv.
    - best_state = lowest index s with npv[s] and npm[s] == m.
    - Go to EMIT.
    - If npv == 0 (cannot occur from a legal pv), pv is reloaded to 8'b0000_0001, pm to 0, and best_state to 0.
  - EMIT:
    - surv_valid = 1; surv_data and best_state are held stable.
    - Leave for IDLE on the first cycle with surv_ready = 1; surv_valid drops that same edge.
    - Back-pressure is unbounded.
- Latency: symbol accepted at edge T; surv_valid is first high in cycle T+10; sym_ready returns the cycle after the surv handshake.
- Minimum throughput: 11 cycles per symbol.
- init (any state):
  - Next edge: pm = 0, pv = 8'b0000_0001, state = IDLE, surv_valid = 0, best_state = 0.
  - An in-flight symbol is discarded with no survivor emitted.
  - init wins over a simultaneous sym_valid; the symbol is not accepted.
- rst mid-operation: identical effect to init, plus surv_data is cleared.
- Metric bound:
  - After NORM the minimum metric is 0 and the spread stays at most 2*4 = 8.
  - PM_SAT clamping is a safety net only; a bench must never observe a clamp in legal operation.

Test Plan:
- Reset, then idle 5 cycles -> sym_ready=1, busy=0, surv_valid=0, best_state=0, all acs_* outputs 0.
- From reset, send sym_data=2'b00 -> after 10 cycles: surv_valid=1, surv_data=8'h00, best_state=0, internal pm[0]=0, pm[1]=2, pv=8'b0000_0011.
- Encode input bits 1,0,1,1,0,0 with G0/G1 error-free and feed them back-to-back with surv_ready=1 -> best_state after each symbol equals the true encoder state (1,2,5,3,6,4); the best metric is always 0.
- Hold surv_ready=0 for 20 cycles in EMIT -> surv_valid and surv_data stable, sym_ready=0, sym_valid ignored; on release, one handshake occurs, then sym_ready=1.
- Pulse init at the 4th ACS cycle -> next cycle IDLE, no surv_valid, pv=8'b0000_0001; the next symbol gives the same result as the post-reset case.
- Assert init and sym_valid in the same IDLE cycle -> symbol not accepted (busy stays 0); 1000 random symbols with random surv_ready -> no pm exceeds 8 after NORM and the PM_SAT clamp never triggers.

Source files
------------

// File: rtl/vit_acs_sched.sv
// vit_acs_sched: add-compare-select scheduler for an 8-state (K=4, rate 1/2) Viterbi decoder.
// Holds the path-metric bank and per-state valid bits. Each accepted symbol is processed by
// driving the external combinational ACS unit once per trellis state. After that the new
// metrics are normalised and one survivor byte plus the best state is offered downstream.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   init              one-cycle pulse: re-initialise metrics, abort any symbol in flight
//   sym_valid/ready   received hard-decision symbol handshake, sym_data = {c1,c0}
//   acs_path_*        drive to the shared ACS unit (zero outside the ACS phase)
//   acs_selection/valid/path_cost   results from the ACS unit
//   surv_valid/ready  survivor byte handshake, surv_data[s] = selection for state s
//   best_state        lowest-index valid state holding the minimum metric
//   busy              high whenever the scheduler is not idle
module vit_acs_sched #(
    parameter logic [3:0] G0     = 4'b1101,
    parameter logic [3:0] G1     = 4'b1111,
    parameter logic [7:0] PM_SAT = 8'd253
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       sym_valid,
    output logic       sym_ready,
    input  logic [1:0] sym_data,
    output logic       acs_path_0_valid,
    output logic       acs_path_1_valid,
    output logic [1:0] acs_path_0_bmc,
    output logic [1:0] acs_path_1_bmc,
    output logic [7:0] acs_path_0_pmc,
    output logic [7:0] acs_path_1_pmc,
    input  logic       acs_selection,
    input  logic       acs_valid,
    input  logic [7:0] acs_path_cost,
    output logic       surv_valid,
    input  logic       surv_ready,
    output logic [7:0] surv_data,
    output logic [2:0] best_state,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StAcs, StNorm, StEmit} state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q;
    logic [1:0] sym_q;
    logic [7:0] pm_q  [8];
    logic [7:0] pv_q;
    logic [7:0] npm_q [8];
    logic [7:0] npv_q;
    logic [7:0] surv_q;
    logic [2:0] best_q;

    logic [2:0] pred_0, pred_1;
    logic       in_bit;
    logic [7:0] norm_min;
    logic [2:0] norm_best;
    logic       norm_found;

    // Hamming distance between the code emitted leaving state p with input u and the symbol.
    function automatic logic [1:0] branch_metric(input logic [2:0] p, input logic u,
                                                 input logic [1:0] sym);
        logic [3:0] vec;
        logic [1:0] diff;
        vec  = {u, p};
        diff = {^(G0 & vec), ^(G1 & vec)} ^ sym;
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    function automatic logic [7:0] sat_metric(input logic [7:0] pm);
        return (pm > PM_SAT) ? PM_SAT : pm;
    endfunction

    // Trellis: state s is reached from {0,s[2:1]} or {1,s[2:1]} with input bit s[0].
    assign pred_0 = {1'b0, idx_q[2:1]};
    assign pred_1 = {1'b1, idx_q[2:1]};
    assign in_bit = idx_q[0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; init overrides everything.
    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (sym_valid) state_d = StAcs;
                StAcs:   if (idx_q == 3'd7) state_d = StNorm;
                StNorm:  state_d = StEmit;
                StEmit:  if (surv_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs and ACS drive.
    always_comb begin
        sym_ready        = (state_q == StIdle) && !init;
        surv_valid       = (state_q == StEmit);
        busy             = (state_q != StIdle);
        acs_path_0_valid = 1'b0;
        acs_path_1_valid = 1'b0;
        acs_path_0_bmc   = 2'd0;
        acs_path_1_bmc   = 2'd0;
        acs_path_0_pmc   = 8'd0;
        acs_path_1_pmc   = 8'd0;
        if (state_q == StAcs) begin
            acs_path_0_valid = pv_q[pred_0];
            acs_path_1_valid = pv_q[pred_1];
            acs_path_0_bmc   = branch_metric(pred_0, in_bit, sym_q);
            acs_path_1_bmc   = branch_metric(pred_1, in_bit, sym_q);
            acs_path_0_pmc   = sat_metric(pm_q[pred_0]);
            acs_path_1_pmc   = sat_metric(pm_q[pred_1]);
        end
    end

    // Minimum over valid new metrics; strict compare keeps the lowest index on ties.
    always_comb begin
        norm_min   = 8'hff;
        norm_best  = 3'd0;
        norm_found = 1'b0;
        for (int s = 0; s < 8; s++) begin
            if (npv_q[s] && (!norm_found || (npm_q[s] < norm_min))) begin
                norm_min   = npm_q[s];
                norm_best  = 3'(s);
                norm_found = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst || init) begin
            for (int s = 0; s < 8; s++) begin
                pm_q[s] <= 8'd0;
            end
            pv_q   <= 8'h01;
            best_q <= 3'd0;
            idx_q  <= 3'd0;
            if (rst) begin
                surv_q <= 8'd0;
                sym_q  <= 2'd0;
                npv_q  <= 8'd0;
                for (int s = 0; s < 8; s++) begin
                    npm_q[s] <= 8'd0;
                end
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (sym_valid) begin
                        sym_q <= sym_data;
                        idx_q <= 3'd0;
                    end
                end
                StAcs: begin
                    npm_q[idx_q]  <= acs_valid ? acs_path_cost : 8'd0;
                    npv_q[idx_q]  <= acs_valid;
                    surv_q[idx_q] <= acs_selection;
                    idx_q         <= idx_q + 3'd1;
                end
                StNorm: begin
                    if (!norm_found) begin
                        // No surviving state: restart the trellis from state 0.
                        for (int s = 0; s < 8; s++) begin
                            pm_q[s] <= 8'd0;
                        end
                        pv_q   <= 8'h01;
                        best_q <= 3'd0;
                    end else begin
                        for (int s = 0; s < 8; s++) begin
                            pm_q[s] <= npv_q[s] ? (npm_q[s] - norm_min) : 8'd0;
                        end
                        pv_q   <= npv_q;
                        best_q <= norm_best;
                    end
                end
                default: ;
            endcase
        end
    end

    assign surv_data  = surv_q;
    assign best_state = best_q;

endmodule
